// File: rtl/mu_alu_arbiter_if.sv
// Bundled request, shared-adder and response signals of the mu-cost adder arbiter.
// The slave modport is the arbiter's view; master is the requester/adder/consumer side.
interface mu_alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         alu_operand_a;
  logic [WIDTH-1:0]         alu_operand_b;
  logic [WIDTH-1:0]         alu_result;
  logic                     alu_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_overflow;

  modport slave (
    input  req_valid, req_a, req_b, alu_result, alu_ready, rsp_ready,
    output req_ready, alu_operand_a, alu_operand_b, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

  modport master (
    output req_valid, req_a, req_b, alu_result, alu_ready, rsp_ready,
    input  req_ready, alu_operand_a, alu_operand_b, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );
endinterface

// File: rtl/mu_alu_arbiter.sv
// Round-robin arbiter sharing one mu-cost adder between NUM_REQ requesters.
// Optional MU_ALU_ARB_SATURATE_EN: clamp rsp_result to all-ones on unsigned carry.
//
// state  | meaning
// IDLE   | searching for a requester from ptr upward; grant is combinational
// ISSUE  | operands held on the adder, waiting for alu_ready
// RESP   | response presented until the consumer takes it
module mu_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  mu_alu_arbiter_if.slave bus,
  output logic          busy,
  output logic [31:0]   op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     rsp_id_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic               rsp_overflow_q;
  logic               rsp_valid_q;

  logic               found;
  logic [IDW-1:0]     winner;
  logic [NUM_REQ-1:0] grant;
  logic               carry;
  logic [WIDTH-1:0]   cap_result;
  logic [IDW-1:0]     next_ptr;

  // Rotating priority search: the first valid requester at or after ptr wins.
  always_comb begin
    logic [IDW:0] cand;
    logic [IDW:0] offs;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    offs   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      offs = (IDW+1)'(k);
      cand = {1'b0, ptr} + offs;
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) begin
      grant[winner] = 1'b1;
    end
  end

  assign bus.req_ready = (rst_n && state == S_IDLE) ? grant : '0;

  // A wrapped unsigned sum is always smaller than either operand.
  assign carry = (bus.alu_result < op_a_q);

`ifdef MU_ALU_ARB_SATURATE_EN
  assign cap_result = carry ? {WIDTH{1'b1}} : bus.alu_result;
`else
  assign cap_result = bus.alu_result;
`endif

  assign next_ptr = (rsp_id_q == LAST_ID) ? '0 : rsp_id_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      ptr            <= '0;
      rsp_id_q       <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      busy           <= 1'b0;
      op_count       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            op_a_q   <= bus.req_a[int'(winner)*WIDTH +: WIDTH];
            op_b_q   <= bus.req_b[int'(winner)*WIDTH +: WIDTH];
            rsp_id_q <= winner;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.alu_ready) begin
            rsp_result_q   <= cap_result;
            rsp_overflow_q <= carry;
            rsp_valid_q    <= 1'b1;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            op_count    <= op_count + 32'd1;
            ptr         <= next_ptr;
            state       <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.alu_operand_a = op_a_q;
  assign bus.alu_operand_b = op_b_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_overflow  = rsp_overflow_q;

endmodule

// File: tb/tb_mu_alu_arbiter.sv
// Directed and randomized bench for mu_alu_arbiter against a transaction-level model.
module tb_mu_alu_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [31:0] op_count;

  mu_alu_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  mu_alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // The shared adder itself.
  assign bus.alu_result = bus.alu_operand_a + bus.alu_operand_b;

  int          total;
  int          bad;
  int          m_ptr;
  logic [31:0] m_count;
  logic [31:0] opa [N];
  logic [31:0] opb [N];
  time         t_acc;
  time         t_prev;
  bit          sat_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_winner(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = opa[i];
      bus.req_b[i*W +: W] = opb[i];
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
      if ($urandom_range(0, 3) == 0) opa[i] = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
    end
    pack();
  endtask

  // One complete transaction: grant, issue with stall cycles, response with back-pressure.
  task automatic run_op(input logic [N-1:0] mask, input int stall, input int bp);
    int          w;
    logic [32:0] s;
    logic [31:0] er;
    logic        eo;
    bus.req_valid = mask;
    bus.alu_ready = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    w = model_winner(mask);
    s = {1'b0, opa[w]} + {1'b0, opb[w]};
    eo = s[32];
    er = (eo && sat_en) ? 32'hFFFF_FFFF : s[31:0];
    check("grant", 32'(bus.req_ready), 32'd1 << w);
    check("idle_busy", 32'(busy), 32'd0);
    tick();
    t_acc = $time;
    check("issue_req_ready", 32'(bus.req_ready), 32'd0);
    check("issue_busy", 32'(busy), 32'd1);
    check("operand_a", bus.alu_operand_a, opa[w]);
    check("operand_b", bus.alu_operand_b, opb[w]);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.alu_ready = 1'b1;
    tick();
    bus.alu_ready = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_id", 32'(bus.rsp_id), 32'(w));
    check("rsp_result", bus.rsp_result, er);
    check("rsp_overflow", 32'(bus.rsp_overflow), 32'(eo));
    if (bp > 0) begin
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        tick();
        check("bp_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_id", 32'(bus.rsp_id), 32'(w));
        check("bp_result", bus.rsp_result, er);
        check("bp_overflow", 32'(bus.rsp_overflow), 32'(eo));
        check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_count", op_count, m_count);
      end
      bus.rsp_ready = 1'b1;
    end
    tick();
    m_count = m_count + 32'd1;
    m_ptr   = (w + 1) % N;
    check("done_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("op_count", op_count, m_count);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    check({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
    check({tag, "_rsp_overflow"}, 32'(bus.rsp_overflow), 32'd0);
    check({tag, "_operand_a"}, bus.alu_operand_a, 32'd0);
    check({tag, "_operand_b"}, bus.alu_operand_b, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_op_count"}, op_count, 32'd0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m_ptr   = 0;
    m_count = '0;
    t_acc   = 0;
    t_prev  = 0;
`ifdef MU_ALU_ARB_SATURATE_EN
    sat_en = 1'b1;
`else
    sat_en = 1'b0;
`endif
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.alu_ready = 1'b0;
    bus.rsp_ready = 1'b1;
    load_random();

    // Reset held with every requester asking: grant must stay low.
    #12;
    check_reset_outputs("reset");
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All requesters valid from reset: strict rotation, one acceptance per 3 cycles.
    for (int k = 0; k < 5; k++) begin
      load_random();
      t_prev = t_acc;
      run_op(4'b1111, 0, 0);
      check("rr_order", 32'(bus.rsp_id), 32'(k % N));
      if (k > 0) check("rr_period", 32'(t_acc - t_prev), 32'd30);
    end

    // Single request from requester 2.
    load_random();
    opa[2] = 32'd5;
    opb[2] = 32'd7;
    pack();
    run_op(4'b0100, 0, 0);
    check("single_result", bus.rsp_result, 32'd12);

    // Carry out of the adder.
    opa[1] = 32'hFFFF_FFFF;
    opb[1] = 32'd2;
    pack();
    run_op(4'b0010, 0, 0);

    // Back-pressure and adder stalls.
    load_random();
    run_op(4'($urandom_range(1, 15)), 0, 5);
    load_random();
    run_op(4'($urandom_range(1, 15)), 3, 0);

    // Nobody asking: stays idle.
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_req_ready", 32'(bus.req_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      load_random();
      run_op(4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while an operation sits in ISSUE.
    load_random();
    run_op(4'b0001, 0, 0);
    bus.req_valid = 4'b0011;
    bus.alu_ready = 1'b0;
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_id", 32'(bus.rsp_id), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_ptr   = 0;
    m_count = '0;
    bus.req_valid = '0;
    bus.alu_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    load_random();
    run_op(4'b1111, 0, 0);
    check("post_reset_prio", 32'(bus.rsp_id), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mu_alu_arbiter.md
# mu_alu_arbiter

Round-robin arbiter and sequencer that shares a single μ-cost adder datapath (32-bit `operand_a + operand_b`, `result`, `ready`) between several requesters. It accepts one request at a time, drives the shared adder with registered operands, captures the sum with an unsigned-overflow flag, and returns it tagged with the requester index. It sits between the μ-cost producers (decode/partition units) and the one adder instance in the μ-accounting path.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width; must match the adder
- IDW, $clog2(NUM_REQ), requester index width

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i
- req_b  in  NUM_REQ*WIDTH  packed operand B
- alu_operand_a  out  WIDTH  to adder operand_a
- alu_operand_b  out  WIDTH  to adder operand_b
- alu_result  in  WIDTH  from adder result
- alu_ready  in  1  from adder ready
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_result  out  WIDTH  sum (see Configuration)
- rsp_overflow  out  1  unsigned carry-out of the sum
- busy  out  1  high in any state other than IDLE
- op_count  out  32  completed responses; wraps at 2^32

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: winner = first i with req_valid[i], searching from ptr upward modulo NUM_REQ. req_ready[winner] = 1 (combinational); all other bits 0. If no req_valid is set, req_ready = 0 and the FSM stays in IDLE. On acceptance: latch req_a/req_b slices into alu_operand_a/b, latch winner into rsp_id, go to ISSUE.
- ISSUE: hold the operands. When alu_ready = 1: capture alu_result and overflow = (alu_result < alu_operand_a), go to RESP. Otherwise stay in ISSUE.
- RESP: rsp_valid = 1. rsp_id, rsp_result and rsp_overflow are stable until rsp_ready = 1. On rsp_valid && rsp_ready: op_count += 1, ptr = (rsp_id + 1) mod NUM_REQ, go to IDLE.
- req_ready is 0 in ISSUE and RESP. Only one operation is in flight.
- A requester that drops req_valid before it is granted is not accepted and is not penalised.
- Fairness: a continuously valid requester is granted within NUM_REQ operations.
- Reset (any state): the FSM returns to IDLE and any in-flight operation is discarded with no response. Reset values: ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_overflow = 0, alu_operand_a/b = 0, busy = 0, op_count = 0. req_ready is forced to 0 while rst_n = 0.

## Timing
- Acceptance cycle N (IDLE, handshake) → ISSUE in N+1 → rsp_valid in N+2 when alu_ready = 1. Latency from acceptance to response is 2 cycles.
- Each extra cycle of alu_ready = 0 in ISSUE adds one cycle of latency.
- With rsp_ready held high, rsp_valid lasts 1 cycle and the next acceptance can occur at N+3. Peak throughput is 1 operation per 3 cycles.
- Back-pressure: rsp_ready = 0 holds RESP indefinitely with all response outputs frozen.

## Configuration
- MU_ALU_ARB_SATURATE_EN defined: when overflow = 1, rsp_result = {WIDTH{1'b1}}. rsp_overflow is still asserted.
- MU_ALU_ARB_SATURATE_EN undefined: rsp_result = alu_result (wrapping sum). rsp_overflow is still asserted on carry.

## Test plan
- Single request: req_valid = 4'b0100, a = 5, b = 7 → req_ready = 4'b0100 for 1 cycle; rsp_valid 2 cycles later with rsp_id = 2, rsp_result = 12, rsp_overflow = 0; op_count = 1.
- All four requesters held valid from reset, rsp_ready = 1 → grant order 0,1,2,3,0; one acceptance every 3 cycles.
- Overflow: a = 0xFFFF_FFFF, b = 2 → rsp_overflow = 1; rsp_result = 0xFFFF_FFFF with the macro defined, 0x0000_0001 without it.
- Back-pressure and stalls: rsp_ready = 0 for 5 cycles → rsp outputs stable, req_ready = 0, busy = 1. Separately, alu_ready = 0 for 3 cycles in ISSUE → rsp_valid delayed by 3 cycles.
- Reset mid-operation: assert rst_n = 0 while in ISSUE → no response is produced; all outputs take their reset values immediately; after release, requester 0 has priority.
